alu_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage that feeds the ALU. It captures decoded instruction fields and register-file reads from decode. It resolves EX/MEM and MEM/WB forwarding and selects shamt/immediate sources. It then presents `oA`, `oB`, `oALUFun` and `oSign` to the ALU's `iA`, `iB`, `iALUFun` and `iSign` inputs, and carries the destination tag forward to EX/MEM.

---
 rtl/alu_operand_stage.sv | 149 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register plus ALU operand select.
// Captures decoded fields and register-file reads. Resolves EX/MEM and MEM/WB
// forwarding, then presents A/B/function/sign to the ALU.
// Optional feature macro: ALU_OPERAND_FWD_EN compiles in the forwarding muxes
// and the stall-time operand refresh. Without it, the stage uses registered
// register-file data only.
module alu_operand_stage #(
  parameter logic [5:0] NOP_FUN = 6'b000000
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iValid,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic [4:0]  iRsNum,
  input  logic [4:0]  iRtNum,
  input  logic [31:0] iRsData,
  input  logic [31:0] iRtData,
  input  logic [31:0] iImm,
  input  logic [4:0]  iShamt,
  input  logic        iALUSrcA,
  input  logic        iALUSrcB,
  input  logic [5:0]  iALUFun,
  input  logic        iSign,
  input  logic [4:0]  iRdNum,
  input  logic        iRegWrite,
  input  logic        iMemFwdWe,
  input  logic [4:0]  iMemFwdRd,
  input  logic [31:0] iMemFwdData,
  input  logic        iWbFwdWe,
  input  logic [4:0]  iWbFwdRd,
  input  logic [31:0] iWbFwdData,
  output logic        oValid,
  output logic [31:0] oA,
  output logic [31:0] oB,
  output logic [5:0]  oALUFun,
  output logic        oSign,
  output logic [4:0]  oRdNum,
  output logic        oRegWrite,
  output logic [31:0] oRtFwd
);

  logic        r_valid;
  logic [4:0]  r_rs_num;
  logic [4:0]  r_rt_num;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_shamt;
  logic        r_src_a;
  logic        r_src_b;
  logic [5:0]  r_alu_fun;
  logic        r_sign;
  logic [4:0]  r_rd_num;
  logic        r_reg_write;

  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

`ifdef ALU_OPERAND_FWD_EN
  // Forward resolution per source: r0 never forwards, EX/MEM beats MEM/WB.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (r_rs_num != 5'd0) begin
      if (iMemFwdWe && (iMemFwdRd == r_rs_num))
        w_fwd_rs = iMemFwdData;
      else if (iWbFwdWe && (iWbFwdRd == r_rs_num))
        w_fwd_rs = iWbFwdData;
    end
    w_fwd_rt = r_rt_data;
    if (r_rt_num != 5'd0) begin
      if (iMemFwdWe && (iMemFwdRd == r_rt_num))
        w_fwd_rt = iMemFwdData;
      else if (iWbFwdWe && (iWbFwdRd == r_rt_num))
        w_fwd_rt = iWbFwdData;
    end
  end
`else
  // Forwarding is compiled out: operands are the registered reads.
  always_comb begin
    w_fwd_rs = r_rs_data;
    w_fwd_rt = r_rt_data;
  end

  // Forward ports and source numbers have no consumer in this build.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{iMemFwdWe, iMemFwdRd, iMemFwdData,
                          iWbFwdWe, iWbFwdRd, iWbFwdData, r_rs_num, r_rt_num};
`endif

  // Pipeline register: flush beats stall, stall beats capture.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_valid     <= 1'b0;
      r_rs_num    <= 5'd0;
      r_rt_num    <= 5'd0;
      r_rs_data   <= 32'd0;
      r_rt_data   <= 32'd0;
      r_imm       <= 32'd0;
      r_shamt     <= 5'd0;
      r_src_a     <= 1'b0;
      r_src_b     <= 1'b0;
      r_alu_fun   <= NOP_FUN;
      r_sign      <= 1'b0;
      r_rd_num    <= 5'd0;
      r_reg_write <= 1'b0;
    end else if (iFlush) begin
      // Bubble: control fields neutralised, operand data left as-is.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_fun   <= NOP_FUN;
      r_sign      <= 1'b0;
      r_rd_num    <= 5'd0;
    end else if (iStall) begin
`ifdef ALU_OPERAND_FWD_EN
      // Latch forwards seen while stalled so they survive the producer retiring.
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
`endif
    end else begin
      r_valid     <= iValid;
      r_rs_num    <= iRsNum;
      r_rt_num    <= iRtNum;
      r_rs_data   <= iRsData;
      r_rt_data   <= iRtData;
      r_imm       <= iImm;
      r_shamt     <= iShamt;
      r_src_a     <= iALUSrcA;
      r_src_b     <= iALUSrcB;
      r_alu_fun   <= iALUFun;
      r_sign      <= iSign;
      r_rd_num    <= iRdNum;
      r_reg_write <= iRegWrite & iValid;
    end
  end

  // Operand select and output drive.
  always_comb begin
    oValid    = r_valid;
    oA        = r_src_a ? {27'b0, r_shamt} : w_fwd_rs;
    oB        = r_src_b ? r_imm : w_fwd_rt;
    oRtFwd    = w_fwd_rt;
    oALUFun   = r_alu_fun;
    oSign     = r_sign;
    oRdNum    = r_rd_num;
    oRegWrite = r_reg_write & r_valid;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage. Expectations are pushed to a
// scoreboard queue when stimulus is applied and popped when outputs are due.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [5:0] NOP = 6'b000000;

  logic        iClk, iRst_n, iValid, iStall, iFlush;
  logic [4:0]  iRsNum, iRtNum, iShamt, iRdNum, iMemFwdRd, iWbFwdRd;
  logic [31:0] iRsData, iRtData, iImm, iMemFwdData, iWbFwdData;
  logic        iALUSrcA, iALUSrcB, iSign, iRegWrite, iMemFwdWe, iWbFwdWe;
  logic [5:0]  iALUFun;
  logic        oValid, oSign, oRegWrite;
  logic [31:0] oA, oB, oRtFwd;
  logic [5:0]  oALUFun;
  logic [4:0]  oRdNum;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rtfwd;
  } exp_t;

  exp_t sb[$];
  exp_t ex, got;
  int   total = 0;
  int   bad   = 0;

  alu_operand_stage #(.NOP_FUN(NOP)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .iStall(iStall), .iFlush(iFlush),
    .iRsNum(iRsNum), .iRtNum(iRtNum), .iRsData(iRsData), .iRtData(iRtData),
    .iImm(iImm), .iShamt(iShamt), .iALUSrcA(iALUSrcA), .iALUSrcB(iALUSrcB),
    .iALUFun(iALUFun), .iSign(iSign), .iRdNum(iRdNum), .iRegWrite(iRegWrite),
    .iMemFwdWe(iMemFwdWe), .iMemFwdRd(iMemFwdRd), .iMemFwdData(iMemFwdData),
    .iWbFwdWe(iWbFwdWe), .iWbFwdRd(iWbFwdRd), .iWbFwdData(iWbFwdData),
    .oValid(oValid), .oA(oA), .oB(oB), .oALUFun(oALUFun), .oSign(oSign),
    .oRdNum(oRdNum), .oRegWrite(oRegWrite), .oRtFwd(oRtFwd)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic exp_t observe();
    exp_t o;
    o = '{oValid, oA, oB, oALUFun, oSign, oRdNum, oRegWrite, oRtFwd};
    return o;
  endfunction

  function automatic exp_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] f, input logic s, input logic [4:0] rd,
                              input logic rw, input logic [31:0] rtf);
    exp_t e;
    e = '{v, a, b, f, s, rd, rw, rtf};
    return e;
  endfunction

  task automatic drive_idle();
    iValid = 0; iStall = 0; iFlush = 0;
    iRsNum = 0; iRtNum = 0; iRsData = 0; iRtData = 0; iImm = 0; iShamt = 0;
    iALUSrcA = 0; iALUSrcB = 0; iALUFun = 0; iSign = 0; iRdNum = 0; iRegWrite = 0;
    iMemFwdWe = 0; iMemFwdRd = 0; iMemFwdData = 0;
    iWbFwdWe = 0; iWbFwdRd = 0; iWbFwdData = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] rsn, input logic [31:0] rsd,
                       input logic [4:0] rtn, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic [4:0] sh, input logic sa, input logic sbsel,
                       input logic [5:0] f, input logic s, input logic [4:0] rd, input logic rw);
    iValid = v; iRsNum = rsn; iRsData = rsd; iRtNum = rtn; iRtData = rtd; iImm = imm;
    iShamt = sh; iALUSrcA = sa; iALUSrcB = sbsel; iALUFun = f; iSign = s;
    iRdNum = rd; iRegWrite = rw;
  endtask

  task automatic test_reset();
    drive_idle();
    iRst_n = 0;
    sb.push_back(mk(0, 0, 0, NOP, 0, 0, 0, 0));
    repeat (2) @(negedge iClk);
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL reset: got %h want %h", got, ex); end
    else $display("ok reset: %h", got);
    iRst_n = 1;
  endtask

  task automatic test_basic();
    @(negedge iClk);
    drive(1, 5'd3, 32'h10, 5'd4, 32'h20, 32'h0, 5'd0, 0, 0, 6'h00, 1, 5'd7, 1);
    sb.push_back(mk(1, 32'h10, 32'h20, 6'h00, 1, 5'd7, 1, 32'h20));
    @(negedge iClk);
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL basic: got %h want %h", got, ex); end
    else $display("ok basic: %h", got);
    // Invalid instruction: regwrite must be dropped even though requested.
    drive(0, 5'd1, 32'h123, 5'd2, 32'h456, 32'h100, 5'd0, 0, 1, 6'h11, 0, 5'd9, 1);
    sb.push_back(mk(0, 32'h123, 32'h100, 6'h11, 0, 5'd9, 0, 32'h456));
    @(negedge iClk);
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL basic_invalid: got %h want %h", got, ex); end
    else $display("ok basic_invalid: %h", got);
  endtask

  task automatic test_fwd_priority();
    drive(1, 5'd5, 32'h1, 5'd6, 32'h2, 32'h0, 5'd0, 0, 0, 6'h01, 0, 5'd8, 1);
    @(negedge iClk);
    iMemFwdWe = 1; iMemFwdRd = 5'd5; iMemFwdData = 32'hAAAA;
    iWbFwdWe  = 1; iWbFwdRd  = 5'd5; iWbFwdData  = 32'hBBBB;
    sb.push_back(mk(1, FWD ? 32'hAAAA : 32'h1, 32'h2, 6'h01, 0, 5'd8, 1, 32'h2));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL fwd_both: got %h want %h", got, ex); end
    else $display("ok fwd_both: %h", got);
    iMemFwdWe = 0;
    sb.push_back(mk(1, FWD ? 32'hBBBB : 32'h1, 32'h2, 6'h01, 0, 5'd8, 1, 32'h2));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL fwd_wb_only: got %h want %h", got, ex); end
    else $display("ok fwd_wb_only: %h", got);
    iWbFwdRd = 5'd6; iWbFwdData = 32'hCCCC;
    sb.push_back(mk(1, 32'h1, FWD ? 32'hCCCC : 32'h2, 6'h01, 0, 5'd8, 1, FWD ? 32'hCCCC : 32'h2));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL fwd_rt_wb: got %h want %h", got, ex); end
    else $display("ok fwd_rt_wb: %h", got);
  endtask

  task automatic test_zero_reg();
    @(negedge iClk);
    drive_idle();
    drive(1, 5'd0, 32'h77, 5'd0, 32'h0, 32'h0, 5'd0, 0, 0, 6'h00, 0, 5'd1, 1);
    @(negedge iClk);
    iMemFwdWe = 1; iMemFwdRd = 5'd0; iMemFwdData = 32'hFFFF;
    iWbFwdWe  = 1; iWbFwdRd  = 5'd0; iWbFwdData  = 32'hEEEE;
    sb.push_back(mk(1, 32'h77, 32'h0, 6'h00, 0, 5'd1, 1, 32'h0));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL zero_reg: got %h want %h", got, ex); end
    else $display("ok zero_reg: %h", got);
  endtask

  task automatic test_shift_imm();
    @(negedge iClk);
    drive_idle();
    drive(1, 5'd2, 32'hDEAD, 5'd8, 32'h99, 32'h0, 5'd7, 1, 0, 6'h20, 0, 5'd4, 1);
    @(negedge iClk);
    iMemFwdWe = 1; iMemFwdRd = 5'd8; iMemFwdData = 32'h1234;
    sb.push_back(mk(1, 32'd7, FWD ? 32'h1234 : 32'h99, 6'h20, 0, 5'd4, 1, FWD ? 32'h1234 : 32'h99));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL sll: got %h want %h", got, ex); end
    else $display("ok sll: %h", got);
    drive(1, 5'd2, 32'hDEAD, 5'd8, 32'h99, 32'hFFFFFFFC, 5'd7, 0, 1, 6'h00, 1, 5'd4, 1);
    @(negedge iClk);
    sb.push_back(mk(1, 32'hDEAD, 32'hFFFFFFFC, 6'h00, 1, 5'd4, 1, FWD ? 32'h1234 : 32'h99));
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL imm_b: got %h want %h", got, ex); end
    else $display("ok imm_b: %h", got);
  endtask

  task automatic test_stall_refresh();
    @(negedge iClk);
    drive_idle();
    drive(1, 5'd10, 32'h22, 5'd9, 32'h11, 32'h0, 5'd0, 0, 0, 6'h05, 0, 5'd3, 1);
    @(negedge iClk);
    iStall = 1;
    drive(0, 5'd1, 32'hBAD0, 5'd1, 32'hBAD1, 32'hBAD2, 5'd1, 1, 1, 6'h3F, 1, 5'd31, 0);
    iWbFwdWe = 1; iWbFwdRd = 5'd9; iWbFwdData = 32'h55;
    sb.push_back(mk(1, 32'h22, FWD ? 32'h55 : 32'h11, 6'h05, 0, 5'd3, 1, FWD ? 32'h55 : 32'h11));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL stall_c1: got %h want %h", got, ex); end
    else $display("ok stall_c1: %h", got);
    @(negedge iClk);
    iWbFwdWe = 0;
    sb.push_back(mk(1, 32'h22, FWD ? 32'h55 : 32'h11, 6'h05, 0, 5'd3, 1, FWD ? 32'h55 : 32'h11));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL stall_c2: got %h want %h", got, ex); end
    else $display("ok stall_c2: %h", got);
    @(negedge iClk);
    sb.push_back(mk(1, 32'h22, FWD ? 32'h55 : 32'h11, 6'h05, 0, 5'd3, 1, FWD ? 32'h55 : 32'h11));
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL stall_after: got %h want %h", got, ex); end
    else $display("ok stall_after: %h", got);
    iStall = 0;
  endtask

  task automatic test_flush();
    @(negedge iClk);
    drive_idle();
    drive(1, 5'd13, 32'h31, 5'd14, 32'h41, 32'h0, 5'd0, 0, 0, 6'h2A, 1, 5'd12, 1);
    sb.push_back(mk(1, 32'h31, 32'h41, 6'h2A, 1, 5'd12, 1, 32'h41));
    @(negedge iClk);
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL pre_flush: got %h want %h", got, ex); end
    else $display("ok pre_flush: %h", got);
    iStall = 1; iFlush = 1;
    drive(1, 5'd15, 32'h99, 5'd16, 32'h98, 32'h0, 5'd0, 0, 0, 6'h2B, 1, 5'd11, 1);
    sb.push_back(mk(0, 32'h31, 32'h41, NOP, 0, 5'd0, 0, 32'h41));
    @(negedge iClk);
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL stall_flush: got %h want %h", got, ex); end
    else $display("ok stall_flush: %h", got);
    iStall = 0; iFlush = 0;
  endtask

  task automatic test_async_reset();
    drive_idle();
    drive(1, 5'd17, 32'h1111, 5'd18, 32'h2222, 32'h0, 5'd0, 0, 0, 6'h07, 1, 5'd19, 1);
    @(negedge iClk);
    iStall = 1;
    #2 iRst_n = 0;
    sb.push_back(mk(0, 0, 0, NOP, 0, 0, 0, 0));
    #1;
    got = observe(); ex = sb.pop_front(); total++;
    if (got !== ex) begin bad++; $display("FAIL async_reset: got %h want %h", got, ex); end
    else $display("ok async_reset: %h", got);
    @(negedge iClk);
    iRst_n = 1; iStall = 0;
  endtask

  task automatic test_back_to_back();
    logic        v, sa, sbsel, s, rw;
    logic [4:0]  rsn, rtn, sh, rd;
    logic [31:0] rsd, rtd, imm;
    logic [5:0]  f;
    drive_idle();
    for (int i = 0; i <= 10; i++) begin
      @(negedge iClk);
      if (i > 0) begin
        got = observe(); ex = sb.pop_front(); total++;
        if (got !== ex) begin bad++; $display("FAIL b2b_%0d: got %h want %h", i, got, ex); end
        else $display("ok b2b_%0d: %h", i, got);
      end
      if (i < 10) begin
        v = 1'($urandom_range(0, 1)); sa = 1'($urandom_range(0, 1));
        sbsel = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
        rw = 1'($urandom_range(0, 1));
        rsn = 5'($urandom_range(0, 31)); rtn = 5'($urandom_range(0, 31));
        sh = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
        rsd = $urandom; rtd = $urandom; imm = $urandom; f = 6'($urandom_range(0, 63));
        drive(v, rsn, rsd, rtn, rtd, imm, sh, sa, sbsel, f, s, rd, rw);
        sb.push_back(mk(v, sa ? {27'b0, sh} : rsd, sbsel ? imm : rtd, f, s, rd, rw & v, rtd));
      end
    end
  endtask

  initial begin
    iRst_n = 1;
    drive_idle();
    #1;
    test_reset();
    test_basic();
    test_fwd_priority();
    test_zero_reg();
    test_shift_imm();
    test_stall_refresh();
    test_flush();
    test_async_reset();
    test_back_to_back();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
